nios_system_de2_req_in: RTL and testbench



---
 rtl/nios_system_pio_pkg.sv | 15 +
 rtl/nios_system_pio_edge_detect.sv | 52 +++++
 rtl/nios_system_de2_req_in.sv | 124 ++++++++++++
 tb/tb_nios_system_de2_req_in.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for Nios II system PIO ports: Avalon register offsets
// and edge-type selector constants used by the input-port edge detector.
package nios_system_pio_pkg;

   // Avalon word offsets within a PIO port
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Edge selection for the capture logic
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage : nios_system_pio_pkg

// File: rtl/nios_system_pio_edge_detect.sv
// Per-bit synchroniser chain, one-cycle-delayed copy of the synced value and
// a combinational edge pulse selected by EDGE_TYPE. Reusable by any PIO
// input port.
module nios_system_pio_edge_detect
   import nios_system_pio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_data,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] sync_chain_r [SYNC_STAGES];
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] sync_s;

   // Synchroniser chain and previous-sample register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_chain_r[i] <= {WIDTH{1'b0}};
         end
         prev_r <= {WIDTH{1'b0}};
      end else begin
         sync_chain_r[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain_r[i] <= sync_chain_r[i-1];
         end
         prev_r <= sync_chain_r[SYNC_STAGES-1];
      end
   end

   assign sync_s    = sync_chain_r[SYNC_STAGES-1];
   assign sync_data = sync_s;

   // Edge pulse for the configured edge type; unknown types fall back to any-edge
   always_comb begin
      edge_pulse = {WIDTH{1'b0}};
      case (EDGE_TYPE)
         EDGE_RISING:  edge_pulse = sync_s & ~prev_r;
         EDGE_FALLING: edge_pulse = ~sync_s & prev_r;
         EDGE_ANY:     edge_pulse = sync_s ^ prev_r;
         default:      edge_pulse = sync_s ^ prev_r;
      endcase
   end

endmodule : nios_system_pio_edge_detect

// File: rtl/nios_system_de2_req_in.sv
// Avalon-MM slave input port for the DE2 request/strobe bus.
// Synchronises in_port, latches edges into edgecapture and raises a maskable
// level interrupt. Build option: define NIOS_SYSTEM_DE2_REQ_BIT_CLEAR_EN to
// make writes to the edgecapture register write-1-to-clear per bit; without
// it any write clears every capture bit.
module nios_system_de2_req_in
   import nios_system_pio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0] readdata,
   output logic        irq
);

   logic [WIDTH-1:0] sync_data_s;
   logic [WIDTH-1:0] edge_pulse_s;
   logic [WIDTH-1:0] irqmask_r;
   logic [WIDTH-1:0] edgecap_r;
   logic [WIDTH-1:0] edgecap_nxt_s;
   logic [WIDTH-1:0] clear_mask_s;
   logic [31:0]      read_mux_s;
   logic [31:0]      readdata_r;
   logic             irq_r;
   logic             write_s;
   logic             unused_wdata_s;

   nios_system_pio_edge_detect #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_detect (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .sync_data  (sync_data_s),
      .edge_pulse (edge_pulse_s)
   );

   assign write_s        = chipselect & ~write_n;
   assign unused_wdata_s = ^writedata;

   // Bits of edgecapture a write to the capture register would clear
   always_comb begin
      clear_mask_s = {WIDTH{1'b0}};
      if (write_s && (address == ADDR_EDGECAP)) begin
`ifdef NIOS_SYSTEM_DE2_REQ_BIT_CLEAR_EN
         clear_mask_s = writedata[WIDTH-1:0];
`else
         clear_mask_s = {WIDTH{1'b1}};
`endif
      end else begin
         clear_mask_s = {WIDTH{1'b0}};
      end
   end

   // Next capture value: a newly detected edge wins over a same-cycle clear
   always_comb begin
      edgecap_nxt_s = (edgecap_r & ~clear_mask_s) | edge_pulse_s;
   end

   // Interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_r <= {WIDTH{1'b0}};
      end else if (write_s && (address == ADDR_IRQMASK)) begin
         irqmask_r <= writedata[WIDTH-1:0];
      end else begin
         irqmask_r <= irqmask_r;
      end
   end

   // Edge-capture register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap_r <= {WIDTH{1'b0}};
      end else begin
         edgecap_r <= edgecap_nxt_s;
      end
   end

   // Read mux, zero-extended to the 32-bit bus
   always_comb begin
      read_mux_s = 32'd0;
      case (address)
         ADDR_DATA:    read_mux_s[WIDTH-1:0] = sync_data_s;
         ADDR_IRQMASK: read_mux_s[WIDTH-1:0] = irqmask_r;
         ADDR_EDGECAP: read_mux_s[WIDTH-1:0] = edgecap_r;
         default:      read_mux_s            = 32'd0;
      endcase
   end

   // Registered read data, updated only while selected
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'd0;
      end else if (chipselect) begin
         readdata_r <= read_mux_s;
      end else begin
         readdata_r <= readdata_r;
      end
   end

   // Registered level interrupt from masked capture bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= |(edgecap_r & irqmask_r);
      end
   end

   assign readdata = readdata_r;
   assign irq      = irq_r;

endmodule : nios_system_de2_req_in

// File: tb/tb_nios_system_de2_req_in.sv
// Self-checking bench for nios_system_de2_req_in (WIDTH=4, rising edges,
// two synchroniser stages). Read expectations go through a scoreboard queue.
module tb_nios_system_de2_req_in;

   localparam int WIDTH = 4;
   localparam int SYNC  = 2;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_checks;
   int n_fail;
   logic [31:0] exp_q [$];

   typedef struct {
      logic [WIDTH-1:0] in_val;
      logic [1:0]       addr;
      logic [31:0]      exp;
   } vec_t;

   vec_t vecs [6];

   nios_system_de2_req_in #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (0),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic do_read(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] e;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(exp);
      tick(1);
      chipselect = 1'b0;
      e = exp_q.pop_front();
      check(name, readdata, e);
   endtask

   initial begin
      int cnt;
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 4'h0;

      vecs[0] = '{4'hA, 2'd0, 32'h0000000A};
      vecs[1] = '{4'hA, 2'd1, 32'h00000000};
      vecs[2] = '{4'h5, 2'd0, 32'h00000005};
      vecs[3] = '{4'hF, 2'd0, 32'h0000000F};
      vecs[4] = '{4'h3, 2'd1, 32'h00000000};
      vecs[5] = '{4'h0, 2'd0, 32'h00000000};

      // Reset state
      tick(3);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      tick(1);
      do_read("rd_data_after_reset", 2'd0, 32'd0);
      do_read("rd_mask_after_reset", 2'd2, 32'd0);
      do_read("rd_cap_after_reset", 2'd3, 32'd0);
      check("irq_after_reset", {31'd0, irq}, 32'd0);

      // Synced data path, table driven
      for (int i = 0; i < 6; i++) begin
         in_port = vecs[i].in_val;
         tick(3);
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Flush pending captures
      tick(4);
      do_write(2'd3, 32'hF);
      do_read("cap_cleared", 2'd3, 32'd0);

      // Rising capture and irq latency
      do_write(2'd2, 32'h1);
      do_read("rd_mask", 2'd2, 32'h1);
      in_port = 4'h1;
      cnt = 0;
      while (irq !== 1'b1 && cnt < 10) begin
         tick(1);
         cnt++;
      end
      check("irq_latency", cnt, SYNC + 2);
      do_read("cap_rise", 2'd3, 32'h1);
      do_write(2'd2, 32'h0);
      check("irq_hold_after_unmask", {31'd0, irq}, 32'd1);
      tick(1);
      check("irq_clear_after_unmask", {31'd0, irq}, 32'd0);
      do_read("cap_kept_after_unmask", 2'd3, 32'h1);

      // Clear and new edge in the same cycle
      in_port = 4'h0;
      tick(4);
      do_write(2'd3, 32'h1);
      do_read("cap_clear_bit0", 2'd3, 32'h0);
      in_port = 4'h1;
      tick(2);
      do_write(2'd3, 32'h1);
      do_read("set_wins_over_clear", 2'd3, 32'h1);

      // Bit clear behaviour
      in_port = 4'h3;
      tick(4);
      do_read("cap_two_bits", 2'd3, 32'h3);
      do_write(2'd3, 32'h1);
`ifdef NIOS_SYSTEM_DE2_REQ_BIT_CLEAR_EN
      do_read("bit_clear", 2'd3, 32'h2);
`else
      do_read("bit_clear", 2'd3, 32'h0);
`endif

      // Mask re-evaluation with pending capture, then async reset
      in_port = 4'h0;
      tick(4);
      in_port = 4'hF;
      tick(4);
      do_read("cap_all", 2'd3, 32'hF);
      do_write(2'd2, 32'hF);
      tick(1);
      check("irq_mask_all", {31'd0, irq}, 32'd1);
      do_read("rd_mask_all", 2'd2, 32'hF);
      #2;
      in_port = 4'h1;
      reset_n = 1'b0;
      #1;
      check("async_reset_irq", {31'd0, irq}, 32'd0);
      check("async_reset_readdata", readdata, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick(2);
      do_read("cap_before_post_reset_edge", 2'd3, 32'h0);
      do_read("cap_post_reset_edge", 2'd3, 32'h1);
      do_read("mask_post_reset", 2'd2, 32'h0);
      check("irq_post_reset", {31'd0, irq}, 32'd0);
      do_read("data_post_reset", 2'd0, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nios_system_de2_req_in
